// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the external SRAM.
// The slave modport is the arbiter's view. The master modport is the view
// of everything around it: the fetch and data requesters plus the SRAM
// read-data return.
`timescale 1ns/1ps
interface sram_arbiter_if;
  // Fetch port (read-only)
  logic        if_req;
  logic [19:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  // Data port (read/write with byte enables)
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [19:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  // SRAM side
  logic [31:0] sram_rdata;
  logic [31:0] sram_wdata;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output sram_wdata, sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  sram_wdata, sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single asynchronous SRAM.
// The fetch port only reads. The data port reads or writes with byte enables.
// Every output comes straight from a flop. The output logic therefore works
// from the next state, so each strobe takes its value on the same edge that
// the FSM enters a state.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 1
) (
  input logic           clk_10M,
  input logic           reset_btn,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  // Terminal values of the phase counter for the stretched read and write phases
  localparam logic [3:0] RdLast = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WrLast = 4'(WR_CYCLES - 1);

  // FSM and the access latched at grant time
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  port_t       winner_q, winner_d;
  port_t       lastGrant_q, lastGrant_d;
  logic [3:0]  latBe_q, latBe_d;

  // Registered outputs
  logic [19:0] sramAddr_q, sramAddr_d;
  logic [31:0] sramWdata_q, sramWdata_d;
  logic [3:0]  sramBeN_q, sramBeN_d;
  logic        sramCeN_q, sramCeN_d;
  logic        sramOeN_q, sramOeN_d;
  logic        sramWeN_q, sramWeN_d;
  logic        ifReady_q, ifReady_d;
  logic        dReady_q, dReady_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic [31:0] dRdata_q, dRdata_d;

  // Round-robin choice.
  // Data wins if it is alone, or if both ports request and fetch had the last grant.
  port_t grantPort;
  assign grantPort = (bus.d_req && (!bus.if_req || (lastGrant_q == PORT_FETCH)))
                     ? PORT_DATA : PORT_FETCH;

  // The read data is sampled during the final cycle of the RD phase
  logic captureRd;
  assign captureRd = (state_q == RD) && (cnt_q == RdLast);

  // State register and all output/latch registers; reset aborts any access in flight
  always_ff @(posedge clk_10M or posedge reset_btn) begin
    if (reset_btn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      winner_q    <= PORT_FETCH;
      lastGrant_q <= PORT_FETCH;
      latBe_q     <= 4'h0;
      sramAddr_q  <= 20'h0;
      sramWdata_q <= 32'h0;
      sramBeN_q   <= 4'hF;
      sramCeN_q   <= 1'b1;
      sramOeN_q   <= 1'b1;
      sramWeN_q   <= 1'b1;
      ifReady_q   <= 1'b0;
      dReady_q    <= 1'b0;
      ifRdata_q   <= 32'h0;
      dRdata_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      lastGrant_q <= lastGrant_d;
      latBe_q     <= latBe_d;
      sramAddr_q  <= sramAddr_d;
      sramWdata_q <= sramWdata_d;
      sramBeN_q   <= sramBeN_d;
      sramCeN_q   <= sramCeN_d;
      sramOeN_q   <= sramOeN_d;
      sramWeN_q   <= sramWeN_d;
      ifReady_q   <= ifReady_d;
      dReady_q    <= dReady_d;
      ifRdata_q   <= ifRdata_d;
      dRdata_q    <= dRdata_d;
    end
  end

  // Next-state logic: grant in IDLE, then walk the fixed phase sequence.
  // The requests are ignored once an access has been granted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    lastGrant_d = lastGrant_q;
    latBe_d     = latBe_q;
    sramAddr_d  = sramAddr_q;
    sramWdata_d = sramWdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          winner_d    = grantPort;
          lastGrant_d = grantPort;
          cnt_d       = 4'd0;
          if (grantPort == PORT_DATA) begin
            sramAddr_d = bus.d_addr;
            latBe_d    = bus.d_be;
            if (bus.d_we) begin
              sramWdata_d = bus.d_wdata;
              state_d     = WR_SETUP;
            end else begin
              state_d = RD;
            end
          end else begin
            sramAddr_d = bus.if_addr;
            latBe_d    = 4'h0;
            state_d    = RD;
          end
        end
      end

      RD: begin
        if (cnt_q == RdLast) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WR_SETUP: begin
        cnt_d   = 4'd0;
        state_d = WR_PULSE;
      end

      WR_PULSE: begin
        if (cnt_q == WrLast) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WR_HOLD: begin
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: strobe levels for the state being entered, ready pulses and rdata capture
  always_comb begin
    sramCeN_d = 1'b1;
    sramOeN_d = 1'b1;
    sramWeN_d = 1'b1;
    sramBeN_d = 4'hF;

    unique case (state_d)
      RD: begin
        sramCeN_d = 1'b0;
        sramOeN_d = 1'b0;
        sramBeN_d = 4'h0;
      end

      WR_SETUP, WR_HOLD: begin
        sramCeN_d = 1'b0;
        sramBeN_d = ~latBe_d;
      end

      WR_PULSE: begin
        sramCeN_d = 1'b0;
        sramBeN_d = ~latBe_d;
        sramWeN_d = (latBe_d == 4'h0);
      end

      default: begin
        sramCeN_d = 1'b1;
      end
    endcase

    ifReady_d = (state_d == DONE) && (winner_q == PORT_FETCH);
    dReady_d  = (state_d == DONE) && (winner_q == PORT_DATA);

    ifRdata_d = (captureRd && (winner_q == PORT_FETCH)) ? bus.sram_rdata : ifRdata_q;
    dRdata_d  = (captureRd && (winner_q == PORT_DATA))  ? bus.sram_rdata : dRdata_q;
  end

  assign bus.if_ready   = ifReady_q;
  assign bus.if_rdata   = ifRdata_q;
  assign bus.d_ready    = dReady_q;
  assign bus.d_rdata    = dRdata_q;
  assign bus.sram_addr  = sramAddr_q;
  assign bus.sram_wdata = sramWdata_q;
  assign bus.sram_be_n  = sramBeN_q;
  assign bus.sram_ce_n  = sramCeN_q;
  assign bus.sram_oe_n  = sramOeN_q;
  assign bus.sram_we_n  = sramWeN_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter.
// Instance dut runs with 1/1 cycle timing and has a byte-writable SRAM model.
// Instance dut2 runs with 3/2 cycle timing and has an address-echo SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic clk_10M = 1'b0;
  logic reset_btn;
  logic memLoad;

  always #50 clk_10M = ~clk_10M;

  sram_arbiter_if bus1();
  sram_arbiter_if bus2();

  sram_arbiter #(.RD_CYCLES(1), .WR_CYCLES(1)) dut (
    .clk_10M  (clk_10M),
    .reset_btn(reset_btn),
    .bus      (bus1)
  );

  sram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(2)) dut2 (
    .clk_10M  (clk_10M),
    .reset_btn(reset_btn),
    .bus      (bus2)
  );

  // 64-word SRAM model for dut.
  // Word i initially holds 0x0101_0101*i, except word 0x10, which holds 0x8000_0000.
  logic [31:0] mem [0:63];

  always @(posedge clk_10M) begin
    if (memLoad) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 16) ? 32'h8000_0000 : 32'h0101_0101 * 32'(i);
    end else if (!bus1.sram_ce_n && !bus1.sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!bus1.sram_be_n[b])
          mem[bus1.sram_addr[5:0]][8*b +: 8] <= bus1.sram_wdata[8*b +: 8];
    end
  end

  assign bus1.sram_rdata = mem[bus1.sram_addr[5:0]];
  assign bus2.sram_rdata = {12'hABC, bus2.sram_addr};

  typedef struct {
    logic        fetchReq;
    logic [19:0] fetchAddr;
    logic        dataReq;
    logic        dataWe;
    logic [3:0]  dataBe;
    logic [19:0] dataAddr;
    logic [31:0] dataWdata;
    logic        expDataPort;
    int          expLat;
    int          expOeLow;
    int          expWeLow;
    logic [3:0]  expBeN;
    logic [19:0] expAddr;
    logic        checkRdata;
    logic [31:0] expRdata;
    logic [31:0] expOtherRdata;
  } vec_t;

  int testsRun = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    bus1.if_req = 1'b0; bus1.if_addr = 20'h0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_be = 4'h0; bus1.d_addr = 20'h0; bus1.d_wdata = 32'h0;
    bus2.if_req = 1'b0; bus2.if_addr = 20'h0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_be = 4'h0; bus2.d_addr = 20'h0; bus2.d_wdata = 32'h0;
  endtask

  // Drives one request and holds it until a ready pulse is seen. Counts the
  // cycles to ready and the cycles with the strobes low. Also snapshots be_n
  // and addr on the first cycle that has ce_n low.
  task automatic applyStimulus(input vec_t v, input bit onSecond,
                               output int lat, output int oeLow, output int weLow,
                               output logic [3:0] beN, output logic [19:0] addr,
                               output logic readyPort, output logic timedOut);
    logic gotFirst;
    logic done;
    @(negedge clk_10M);
    if (onSecond) begin
      bus2.if_req = v.fetchReq; bus2.if_addr = v.fetchAddr; bus2.d_req = v.dataReq;
      bus2.d_we = v.dataWe; bus2.d_be = v.dataBe; bus2.d_addr = v.dataAddr;
      bus2.d_wdata = v.dataWdata;
    end else begin
      bus1.if_req = v.fetchReq; bus1.if_addr = v.fetchAddr; bus1.d_req = v.dataReq;
      bus1.d_we = v.dataWe; bus1.d_be = v.dataBe; bus1.d_addr = v.dataAddr;
      bus1.d_wdata = v.dataWdata;
    end
    lat = 0; oeLow = 0; weLow = 0; beN = 4'hx; addr = 20'hx;
    readyPort = 1'bx; gotFirst = 1'b0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk_10M);
      lat++;
      if (!(onSecond ? bus2.sram_oe_n : bus1.sram_oe_n)) oeLow++;
      if (!(onSecond ? bus2.sram_we_n : bus1.sram_we_n)) weLow++;
      if (!gotFirst && !(onSecond ? bus2.sram_ce_n : bus1.sram_ce_n)) begin
        gotFirst = 1'b1;
        beN  = onSecond ? bus2.sram_be_n : bus1.sram_be_n;
        addr = onSecond ? bus2.sram_addr : bus1.sram_addr;
      end
      if (onSecond ? (bus2.if_ready || bus2.d_ready) : (bus1.if_ready || bus1.d_ready)) begin
        done = 1'b1;
        readyPort = onSecond ? bus2.d_ready : bus1.d_ready;
      end
    end
    timedOut = !done;
    driveIdle();
  endtask

  task automatic runVector(input vec_t v, input bit onSecond, input string tag);
    int lat, oeLow, weLow;
    logic [3:0] beN;
    logic [19:0] addr;
    logic readyPort, timedOut;
    logic [31:0] ownRdata, otherRdata;
    applyStimulus(v, onSecond, lat, oeLow, weLow, beN, addr, readyPort, timedOut);
    checkOutput({tag, ".timeout"}, 32'(timedOut), 32'(0));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, ".readyPort"}, 32'(readyPort), 32'(v.expDataPort));
    checkOutput({tag, ".oeLowCycles"}, 32'(oeLow), 32'(v.expOeLow));
    checkOutput({tag, ".weLowCycles"}, 32'(weLow), 32'(v.expWeLow));
    checkOutput({tag, ".beN"}, 32'(beN), 32'(v.expBeN));
    checkOutput({tag, ".addr"}, 32'(addr), 32'(v.expAddr));
    if (onSecond) begin
      ownRdata   = v.expDataPort ? bus2.d_rdata : bus2.if_rdata;
      otherRdata = v.expDataPort ? bus2.if_rdata : bus2.d_rdata;
    end else begin
      ownRdata   = v.expDataPort ? bus1.d_rdata : bus1.if_rdata;
      otherRdata = v.expDataPort ? bus1.if_rdata : bus1.d_rdata;
    end
    if (v.checkRdata) checkOutput({tag, ".rdata"}, ownRdata, v.expRdata);
    checkOutput({tag, ".otherRdata"}, otherRdata, v.expOtherRdata);
    @(negedge clk_10M);
    checkOutput({tag, ".readyOneCycle"},
                32'(onSecond ? (bus2.if_ready | bus2.d_ready) : (bus1.if_ready | bus1.d_ready)),
                32'(0));
  endtask

  vec_t vecs [0:7];
  vec_t vecs2 [0:2];
  vec_t rb;

  initial begin
    int cyc;
    int grants;
    logic [3:0] order;

    // fetch/data, addr/we/be/wdata, port, lat, oeLow, weLow, beN, addr, chk, rdata, other
    vecs[0] = '{1'b1, 20'h10, 1'b0, 1'b0, 4'h0,    20'h0,  32'h0,          1'b0, 2, 1, 0, 4'h0,    20'h10, 1'b1, 32'h8000_0000, 32'h0};
    vecs[1] = '{1'b0, 20'h0,  1'b1, 1'b1, 4'b0011, 20'h20, 32'hDEAD_BEEF,  1'b1, 4, 0, 1, 4'b1100, 20'h20, 1'b0, 32'h0,         32'h8000_0000};
    vecs[2] = '{1'b0, 20'h0,  1'b1, 1'b0, 4'h0,    20'h20, 32'h0,          1'b1, 2, 1, 0, 4'h0,    20'h20, 1'b1, 32'h2020_BEEF, 32'h8000_0000};
    vecs[3] = '{1'b0, 20'h0,  1'b1, 1'b1, 4'b0000, 20'h21, 32'hCAFE_F00D,  1'b1, 4, 0, 0, 4'hF,    20'h21, 1'b0, 32'h0,         32'h8000_0000};
    vecs[4] = '{1'b0, 20'h0,  1'b1, 1'b0, 4'h0,    20'h21, 32'h0,          1'b1, 2, 1, 0, 4'h0,    20'h21, 1'b1, 32'h2121_2121, 32'h8000_0000};
    vecs[5] = '{1'b0, 20'h0,  1'b1, 1'b1, 4'b1001, 20'h22, 32'hAABB_CCDD,  1'b1, 4, 0, 1, 4'b0110, 20'h22, 1'b0, 32'h0,         32'h8000_0000};
    vecs[6] = '{1'b1, 20'h22, 1'b0, 1'b0, 4'h0,    20'h0,  32'h0,          1'b0, 2, 1, 0, 4'h0,    20'h22, 1'b1, 32'hAA22_22DD, 32'h2121_2121};
    vecs[7] = '{1'b1, 20'h3F, 1'b0, 1'b0, 4'h0,    20'h0,  32'h0,          1'b0, 2, 1, 0, 4'h0,    20'h3F, 1'b1, 32'h3F3F_3F3F, 32'h2121_2121};

    vecs2[0] = '{1'b1, 20'h5, 1'b0, 1'b0, 4'h0,    20'h0, 32'h0,  1'b0, 4, 3, 0, 4'h0, 20'h5, 1'b1, 32'hABC0_0005, 32'h0};
    vecs2[1] = '{1'b0, 20'h0, 1'b1, 1'b1, 4'b1111, 20'h7, 32'h55, 1'b1, 5, 0, 2, 4'h0, 20'h7, 1'b0, 32'h0,         32'hABC0_0005};
    vecs2[2] = '{1'b0, 20'h0, 1'b1, 1'b0, 4'h0,    20'h9, 32'h0,  1'b1, 4, 3, 0, 4'h0, 20'h9, 1'b1, 32'hABC0_0009, 32'hABC0_0005};

    rb = '{1'b0, 20'h0, 1'b1, 1'b0, 4'h0, 20'h30, 32'h0, 1'b1, 2, 1, 0, 4'h0, 20'h30, 1'b1, 32'h1234_5678, 32'h0};

    // Reset state
    driveIdle();
    reset_btn = 1'b1;
    memLoad   = 1'b1;
    repeat (2) @(negedge clk_10M);
    memLoad = 1'b0;
    checkOutput("rst.ce_n", 32'(bus1.sram_ce_n), 32'(1));
    checkOutput("rst.oe_n", 32'(bus1.sram_oe_n), 32'(1));
    checkOutput("rst.we_n", 32'(bus1.sram_we_n), 32'(1));
    checkOutput("rst.be_n", 32'(bus1.sram_be_n), 32'hF);
    checkOutput("rst.addr", 32'(bus1.sram_addr), 32'h0);
    checkOutput("rst.wdata", bus1.sram_wdata, 32'h0);
    checkOutput("rst.ready", 32'({bus1.if_ready, bus1.d_ready}), 32'(0));
    checkOutput("rst.if_rdata", bus1.if_rdata, 32'h0);
    checkOutput("rst.d_rdata", bus1.d_rdata, 32'h0);
    checkOutput("rst2.strobes", 32'({bus2.sram_ce_n, bus2.sram_oe_n, bus2.sram_we_n}), 32'h7);
    reset_btn = 1'b0;
    @(negedge clk_10M);

    // Single-requester transactions on dut
    for (int i = 0; i < 8; i++)
      runVector(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset asserted in the middle of the write pulse
    @(negedge clk_10M);
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_be = 4'hF;
    bus1.d_addr = 20'h30; bus1.d_wdata = 32'h1234_5678;
    cyc = 0;
    while (bus1.sram_we_n !== 1'b0 && cyc < 10) begin
      @(negedge clk_10M);
      cyc++;
    end
    checkOutput("rstMid.reachPulse", 32'(cyc), 32'(2));
    #10 reset_btn = 1'b1;
    #1;
    checkOutput("rstMid.we_n", 32'(bus1.sram_we_n), 32'(1));
    checkOutput("rstMid.ce_n", 32'(bus1.sram_ce_n), 32'(1));
    checkOutput("rstMid.d_ready", 32'(bus1.d_ready), 32'(0));
    @(negedge clk_10M);
    checkOutput("rstMid.noReadyInReset", 32'(bus1.d_ready), 32'(0));
    reset_btn = 1'b0;
    cyc = 0;
    while (!bus1.d_ready && cyc < 20) begin
      @(negedge clk_10M);
      cyc++;
    end
    checkOutput("rstMid.reissueLatency", 32'(cyc), 32'(4));
    driveIdle();
    @(negedge clk_10M);
    runVector(rb, 1'b0, "rstMid.readBack");

    // Both ports request continuously after reset; data must win the first tie
    @(negedge clk_10M);
    reset_btn = 1'b1;
    @(negedge clk_10M);
    reset_btn = 1'b0;
    bus1.if_req = 1'b1; bus1.if_addr = 20'h10;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 20'h21;
    grants = 0; order = 4'h0; cyc = 0;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk_10M);
      cyc++;
      if (bus1.d_ready) begin
        order[grants] = 1'b1;
        grants++;
      end else if (bus1.if_ready) begin
        order[grants] = 1'b0;
        grants++;
      end
    end
    driveIdle();
    checkOutput("tie.grantCount", 32'(grants), 32'(4));
    checkOutput("tie.order", 32'(order), 32'(4'b0101));
    checkOutput("tie.cycles", 32'(cyc), 32'(11));
    checkOutput("tie.if_rdata", bus1.if_rdata, 32'h8000_0000);
    checkOutput("tie.d_rdata", bus1.d_rdata, 32'h2121_2121);

    // Stretched timing on dut2
    for (int i = 0; i < 3; i++)
      runVector(vecs2[i], 1'b1, $sformatf("slow%0d", i));

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RD_CYCLES  1  cycles SRAM is driven for a read (legal 1..15)
  WR_CYCLES  1  cycles sram_we_n is held low for a write (legal 1..15)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_10M  in  1  system clock
  reset_btn  in  1  reset, asynchronous, active-high
  if_req  in  1  fetch port request (read-only)
  if_addr  in  20  fetch word address
  if_ready  out  1  fetch done pulse
  if_rdata  out  32  fetch read data
  d_req  in  1  data port request
  d_we  in  1  1=write, 0=read
  d_be  in  4  byte enables, active-high
  d_addr  in  20  data word address
  d_wdata  in  32  write data
  d_ready  out  1  data done pulse
  d_rdata  out  32  data read data
  sram_rdata  in  32  SRAM data bus input
  sram_wdata  out  32  SRAM write data (top level drives bus when sram_we_n=0)
  sram_addr  out  20  SRAM address
  sram_be_n  out  4  SRAM byte enables, active-low
  sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active-low
REQ-003 Reset SHALL be reset_btn, asynchronous, active-high; clock SHALL be clk_10M.

Function
REQ-004 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-005 Handshake: a requester SHALL hold req and all fields stable until its ready pulse; ready SHALL be high for exactly one cycle; rdata SHALL be valid in the ready cycle and held until the next read completion on that port.
REQ-006 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-007 IDLE: if any req is high, the arbiter SHALL select a winner, latch its addr/we/be/wdata, and move to RD (read) or WR_SETUP (write) next cycle; otherwise stay.
REQ-008 Arbitration SHALL be round-robin: when both requests are high, the port not granted last wins; a single requester always wins; last-granted resets to fetch, so data wins the first tie.
REQ-009 RD SHALL last RD_CYCLES cycles with ce_n=0, oe_n=0, we_n=1, be_n=4'b0000, addr=latched address; on its last cycle sram_rdata SHALL be captured into the winner's rdata register.
REQ-010 WR_SETUP SHALL last 1 cycle with ce_n=0, oe_n=1, we_n=1, addr, sram_wdata and be_n=~d_be driven.
REQ-011 WR_PULSE SHALL last WR_CYCLES cycles with we_n=0, all else as WR_SETUP.
REQ-012 WR_HOLD SHALL last 1 cycle with we_n=1, ce_n=0, addr/wdata/be_n unchanged.
REQ-013 DONE SHALL last 1 cycle, assert the winner's ready, drive ce_n=oe_n=we_n=1 and be_n=4'b1111, then return to IDLE; no new request is accepted in DONE.
REQ-014 Latency from req-sampled IDLE cycle to ready: read RD_CYCLES+1 cycles, write WR_CYCLES+3 cycles; back-to-back throughput one read per RD_CYCLES+2 cycles.
REQ-015 Write with d_be=4'b0000 SHALL follow the same sequence and latency but keep we_n=1 throughout.
REQ-016 sram_addr and sram_wdata SHALL hold their last values in IDLE/DONE; if_rdata is never changed by a data access and vice versa.
REQ-017 Requests dropped before ready (protocol violation) SHALL NOT abort an access in progress.

Reset
REQ-018 On reset_btn: state=IDLE, ce_n=oe_n=we_n=1, be_n=4'b1111, sram_addr=0, sram_wdata=0, if_ready=d_ready=0, if_rdata=d_rdata=0, last-granted=fetch.
REQ-019 Reset mid-access SHALL abort immediately with no ready pulse; requesters re-issue after release.

Verification
REQ-020 Fetch read addr 0x00010, SRAM model returns 0x8000_0000 -> if_ready at cycle +2, if_rdata=0x8000_0000, oe_n low exactly 1 cycle.
REQ-021 Data write addr 0x00020, wdata 0xDEAD_BEEF, be=4'b0011 -> we_n low 1 cycle preceded and followed by 1 cycle with we_n high/ce_n low, be_n=4'b1100, d_ready at cycle +4.
REQ-022 if_req and d_req asserted together, held continuously -> grants alternate data, fetch, data, fetch; neither port starves.
REQ-023 Data write with be=4'b0000 -> d_ready at cycle +4, we_n never low.
REQ-024 reset_btn pulsed during WR_PULSE -> we_n=1, ce_n=1 immediately, no d_ready; re-issued write completes normally.
REQ-025 RD_CYCLES=3, WR_CYCLES=2 -> read latency 4, write latency 5, strobe widths 3 and 2 cycles.
